// File: rtl/hyper_resp_if.sv
// HyperBus pin bundle between a controller and the responder.
// master = controller side, slave = device side.
interface hyper_resp_if;
    logic       hb_ck;
    logic       hb_cs_l;
    logic       hb_rst_l;
    logic [7:0] hb_dq_in;
    logic [7:0] hb_dq_out;
    logic       hb_dq_oe;
    logic       hb_rwds_in;
    logic       hb_rwds_out;
    logic       hb_rwds_oe;

    modport master (
        output hb_ck, hb_cs_l, hb_rst_l,
        output hb_dq_in, hb_rwds_in,
        input  hb_dq_out, hb_dq_oe,
        input  hb_rwds_out, hb_rwds_oe
    );

    modport slave (
        input  hb_ck, hb_cs_l, hb_rst_l,
        input  hb_dq_in, hb_rwds_in,
        output hb_dq_out, hb_dq_oe,
        output hb_rwds_out, hb_rwds_oe
    );
endinterface

// File: rtl/hyper_resp.sv
// HyperBus memory responder: oversamples hb_ck on clk, decodes CA,
// applies initial latency, serves reads and byte-masked writes.
module hyper_resp #(
    parameter int          AW       = 10,
    parameter int          LATENCY  = 6,
    parameter bit          LAT2X    = 1'b1,
    parameter logic [15:0] CFG0_RST = 16'h8F1F
) (
    input  logic         clk,
    input  logic         rstn,
    hyper_resp_if.slave  hb,
    output logic         busy,
    output logic [15:0]  txn_count
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CA   = 3'd1;
    localparam logic [2:0] LAT  = 3'd2;
    localparam logic [2:0] RD   = 3'd3;
    localparam logic [2:0] WR   = 3'd4;

    localparam int         LAT_CYC  = LATENCY * (LAT2X ? 2 : 1);
    localparam logic [7:0] LAT_INIT = 8'(LAT_CYC - 1);

    logic [2:0]    state;
    logic          ck_q;
    logic [47:0]   ca;
    logic [2:0]    byte_cnt;
    logic [7:0]    lat_cnt;
    logic [AW-1:0] addr;
    logic          is_rd;
    logic          is_reg;
    logic          done;
    logic [7:0]    wr_hi;
    logic          mask_hi;
    logic [15:0]   cfg0;
    logic [15:0]   mem [2**AW];

    logic          rise;
    logic          fall;
    logic          ck_edge;
    logic [47:0]   ca_n;
    logic [31:0]   ca_addr;
    logic [15:0]   rd_word;
    logic          mem_we;
    logic          unused;

    assign rise    = hb.hb_ck & ~ck_q;
    assign fall    = ~hb.hb_ck & ck_q;
    assign ck_edge = rise | fall;
    assign ca_n    = {ca[39:0], hb.hb_dq_in};
    assign ca_addr = {ca_n[44:16], ca_n[2:0]};
    assign rd_word = is_reg ? cfg0 : mem[addr];
    assign busy    = (state != IDLE);
    assign unused  = ^{ca[47:40], ca_n[45],
                       ca_n[15:3], ca_addr[31:AW]};

    // Commit happens on the low-byte fall, unless CS or device reset kill it.
    assign mem_we = rstn & hb.hb_rst_l & ~hb.hb_cs_l
                  & (state == WR) & fall & ~is_reg;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!mask_hi)
                mem[addr][15:8] <= wr_hi;
            if (!hb.hb_rwds_in)
                mem[addr][7:0] <= hb.hb_dq_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            ck_q           <= 1'b0;
            ca             <= '0;
            byte_cnt       <= '0;
            lat_cnt        <= '0;
            addr           <= '0;
            is_rd          <= 1'b0;
            is_reg         <= 1'b0;
            done           <= 1'b0;
            wr_hi          <= '0;
            mask_hi        <= 1'b0;
            cfg0           <= CFG0_RST;
            txn_count      <= '0;
            hb.hb_dq_out   <= '0;
            hb.hb_dq_oe    <= 1'b0;
            hb.hb_rwds_out <= 1'b0;
            hb.hb_rwds_oe  <= 1'b0;
        end else begin
            ck_q <= hb.hb_ck;
            if (!hb.hb_rst_l) begin
                state          <= IDLE;
                cfg0           <= CFG0_RST;
                done           <= 1'b0;
                hb.hb_dq_out   <= '0;
                hb.hb_dq_oe    <= 1'b0;
                hb.hb_rwds_out <= 1'b0;
                hb.hb_rwds_oe  <= 1'b0;
            end else if (hb.hb_cs_l) begin
                // Deassertion beats any ck edge seen on the same clk.
                state         <= IDLE;
                done          <= 1'b0;
                hb.hb_dq_oe   <= 1'b0;
                hb.hb_rwds_oe <= 1'b0;
                if ((state == RD || state == WR) && done)
                    txn_count <= txn_count + 16'd1;
            end else begin
                case (state)
                    IDLE: begin
                        state          <= CA;
                        byte_cnt       <= '0;
                        hb.hb_rwds_oe  <= 1'b1;
                        hb.hb_rwds_out <= LAT2X;
                    end
                    CA: if (ck_edge) begin
                        ca       <= ca_n;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd5) begin
                            is_rd   <= ca_n[47];
                            is_reg  <= ca_n[46];
                            addr    <= ca_addr[AW-1:0];
                            done    <= 1'b0;
                            lat_cnt <= LAT_INIT;
                            if (ca_n[47])
                                hb.hb_rwds_out <= 1'b0;
                            else
                                hb.hb_rwds_oe <= 1'b0;
                            state <= (ca_n[46] && !ca_n[47])
                                   ? WR : LAT;
                        end
                    end
                    LAT: if (rise) begin
                        if (lat_cnt == 8'd0) begin
                            // This rise already carries the first data byte.
                            if (is_rd) begin
                                state          <= RD;
                                hb.hb_dq_oe    <= 1'b1;
                                hb.hb_dq_out   <= rd_word[15:8];
                                hb.hb_rwds_out <= 1'b1;
                            end else begin
                                state   <= WR;
                                wr_hi   <= hb.hb_dq_in;
                                mask_hi <= hb.hb_rwds_in;
                            end
                        end else begin
                            lat_cnt <= lat_cnt - 8'd1;
                        end
                    end
                    RD: begin
                        if (rise) begin
                            hb.hb_dq_oe    <= 1'b1;
                            hb.hb_dq_out   <= rd_word[15:8];
                            hb.hb_rwds_out <= 1'b1;
                        end else if (fall) begin
                            hb.hb_dq_out   <= rd_word[7:0];
                            hb.hb_rwds_out <= 1'b0;
                            addr           <= addr + AW'(1);
                            done           <= 1'b1;
                        end
                    end
                    WR: begin
                        if (rise) begin
                            wr_hi   <= hb.hb_dq_in;
                            mask_hi <= hb.hb_rwds_in;
                        end else if (fall) begin
                            if (is_reg)
                                cfg0 <= {wr_hi, hb.hb_dq_in};
                            addr <= addr + AW'(1);
                            done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hyper_resp.sv
// Directed bench for hyper_resp: expected read bytes are queued by the
// stimulus and consumed by an independent output monitor.
module tb_hyper_resp;
    localparam int HALF = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        busy;
    logic [15:0] txn_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_txn = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_b;
    logic        prev_oe = 1'b0;
    logic        prev_rwds = 1'b0;

    hyper_resp_if hb();

    hyper_resp #(
        .AW(10), .LATENCY(6), .LAT2X(1'b1),
        .CFG0_RST(16'h8F1F)
    ) dut (
        .clk(clk), .rstn(rstn), .hb(hb),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [15:0] got,
                         input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Each new read byte shows as dq_oe rising or an rwds toggle.
    always @(negedge clk) begin
        if (rstn && hb.hb_dq_oe &&
            (!prev_oe || hb.hb_rwds_out != prev_rwds)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h want none",
                         {hb.hb_rwds_out, hb.hb_dq_out});
            end else begin
                exp_b = exp_q.pop_front();
                check("rd_byte",
                      16'({hb.hb_rwds_out, hb.hb_dq_out}),
                      16'(exp_b));
            end
        end
        prev_oe   = hb.hb_dq_oe;
        prev_rwds = hb.hb_rwds_out;
    end

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic [7:0] d,
                       input logic m);
        hb.hb_ck      = v;
        hb.hb_dq_in   = d;
        hb.hb_rwds_in = m;
        wait_half();
    endtask

    task automatic begin_txn(input logic [47:0] ca);
        hb.hb_cs_l = 1'b0;
        wait_half();
        for (int i = 0; i < 6; i++)
            drv(i % 2 == 0, ca[47-8*i -: 8], 1'b0);
    endtask

    task automatic latency();
        for (int i = 0; i < 11; i++) begin
            drv(1'b1, 8'h00, 1'b0);
            drv(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic do_write(input logic [47:0] ca, input int n,
                            input logic [15:0] w0, w1,
                            input logic [1:0] m0, m1);
        logic [15:0] w;
        logic [1:0]  m;
        begin_txn(ca);
        if (ca[47] || !ca[46])
            latency();
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : w1;
            m = (k == 0) ? m0 : m1;
            drv(1'b1, w[15:8], m[1]);
            drv(1'b0, w[7:0], m[0]);
        end
        hb.hb_cs_l = 1'b1;
        wait_half();
        exp_txn++;
    endtask

    task automatic do_read(input logic [47:0] ca, input int n,
                           input logic [15:0] e0, e1);
        logic [15:0] e;
        for (int k = 0; k < n; k++) begin
            e = (k == 0) ? e0 : e1;
            exp_q.push_back({1'b1, e[15:8]});
            exp_q.push_back({1'b0, e[7:0]});
        end
        begin_txn(ca);
        latency();
        check("lat_no_oe", 16'(hb.hb_dq_oe), 16'd0);
        for (int k = 0; k < n; k++) begin
            drv(1'b1, 8'h00, 1'b0);
            drv(1'b0, 8'h00, 1'b0);
        end
        hb.hb_cs_l = 1'b1;
        check("oe_at_cs", 16'(hb.hb_dq_oe), 16'd1);
        @(negedge clk);
        check("oe_after_cs", 16'(hb.hb_dq_oe), 16'd0);
        @(negedge clk);
        check("sb_drain", 16'(exp_q.size()), 16'd0);
        exp_txn++;
    endtask

    initial begin
        rstn          = 1'b0;
        hb.hb_ck      = 1'b0;
        hb.hb_cs_l    = 1'b1;
        hb.hb_rst_l   = 1'b1;
        hb.hb_dq_in   = 8'h00;
        hb.hb_rwds_in = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_outs",
              16'({hb.hb_dq_out, hb.hb_dq_oe, hb.hb_rwds_out,
                   hb.hb_rwds_oe, busy}), 16'd0);
        check("rst_txn", txn_count, 16'd0);

        do_write(48'h000000000002, 2, 16'h1234, 16'h5678,
                 2'b00, 2'b00);
        check("txn_w1", txn_count, 16'(exp_txn));
        do_read(48'h800000000002, 2, 16'h1234, 16'h5678);

        do_write(48'h000000000002, 1, 16'hAABB, 16'h0000,
                 2'b01, 2'b00);
        do_read(48'h800000000002, 1, 16'hAA34, 16'h0000);
        do_read(48'hC00000000000, 1, 16'h8F1F, 16'h0000);

        do_write(48'h0000007F0007, 2, 16'hBEEF, 16'h0F0F,
                 2'b00, 2'b00);
        do_read(48'h8000007F0007, 2, 16'hBEEF, 16'h0F0F);
        do_read(48'h800000000000, 1, 16'h0F0F, 16'h0000);

        do_write(48'h600001000000, 1, 16'h8FE6, 16'h0000,
                 2'b11, 2'b00);
        do_read(48'hC00000000000, 1, 16'h8FE6, 16'h0000);

        do_write(48'h000000000005, 1, 16'hCAFE, 16'h0000,
                 2'b00, 2'b00);
        begin_txn(48'h000000000005);
        latency();
        drv(1'b1, 8'hDE, 1'b0);
        hb.hb_cs_l  = 1'b1;
        hb.hb_ck    = 1'b0;
        hb.hb_dq_in = 8'hAD;
        @(negedge clk);
        check("abort_busy", 16'(busy), 16'd0);
        wait_half();
        check("abort_txn", txn_count, 16'(exp_txn));
        do_read(48'h800000000005, 1, 16'hCAFE, 16'h0000);

        hb.hb_rst_l = 1'b0;
        wait_half();
        check("hbrst_busy", 16'(busy), 16'd0);
        hb.hb_rst_l = 1'b1;
        wait_half();
        check("hbrst_txn", txn_count, 16'(exp_txn));
        do_read(48'hC00000000000, 1, 16'h8F1F, 16'h0000);
        check("txn_final", txn_count, 16'(exp_txn));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hyper_resp.md
Name: hyper_resp

Overview:
Synthesizable HyperBus memory responder: the device end of the HyperRAM link that the controller drives. It decodes command/address, applies the initial latency, returns read data with an RWDS strobe, and stores write data under byte mask in an internal word array. All HyperBus inputs are oversampled by the system clock, which makes it a drop-in target for controller regression and on-board loopback.

Parameters:
AW, 10, word address width; the array holds 2^AW 16-bit words
LATENCY, 6, initial latency in CK cycles (1x)
LAT2X, 1, 1 = always use double latency; RWDS is driven high during CA
CFG0_RST, 16'h8F1F, reset value of the configuration register

Ports:
clk  in  1  system clock; must be at least 4x the hb_ck frequency
rstn  in  1  asynchronous active-low reset
hb_ck  in  1  HyperBus clock, sampled on clk
hb_cs_l  in  1  chip select, active low
hb_rst_l  in  1  device reset, active low; acts as a synchronous reset to IDLE
hb_dq_in  in  8  DQ input
hb_dq_out  out  8  DQ output
hb_dq_oe  out  1  DQ output enable
hb_rwds_in  in  1  RWDS input; write byte mask, 1 = masked
hb_rwds_out  out  1  RWDS output
hb_rwds_oe  out  1  RWDS output enable
busy  out  1  high whenever the state is not IDLE
txn_count  out  16  count of completed transactions; wraps at 0xFFFF

Behaviour:
- Reset (rstn low, async), or hb_rst_l low on a clk edge: state IDLE; hb_dq_out=0, hb_dq_oe=0, hb_rwds_out=0, hb_rwds_oe=0, busy=0, txn_count=0; cfg0=CFG0_RST. hb_rst_l does not clear txn_count or the array.
- Edge detection: ck_q holds hb_ck delayed one clk. A rise is hb_ck=1 with ck_q=0; a fall is the inverse. Every data sample or drive step occurs on a clk cycle with a detected edge.
- Outputs are registered: output changes appear one clk after the detecting cycle.
- States: IDLE, CA, LAT, RD, WR.
  - IDLE: hb_cs_l low -> CA. Reset the byte counter, set hb_rwds_oe=1 and hb_rwds_out=LAT2X.
  - CA: capture one byte per ck edge, MSB first, into ca[47:0]. Six bytes take 3 ck cycles.
  - CA decode: ca[47]=1 read; ca[46]=1 register space; ca[45] burst type, always treated as linear. Word address = {ca[44:16], ca[2:0]}, truncated to AW bits.
  - After the 6th byte:
    - Register write: go straight to WR with zero latency.
    - Otherwise: lat_cnt = LATENCY*(LAT2X?2:1)-1 and go to LAT. For writes, hb_rwds_oe drops at CA end; for reads it stays high and is driven 0.
  - LAT: decrement lat_cnt on each ck rise. On a rise with lat_cnt=0, go to RD or WR; that rise is the first data edge.
  - RD:
    - hb_dq_oe=1.
    - Rise: drive mem[addr][15:8] and hb_rwds_out=1.
    - Fall: drive mem[addr][7:0] and hb_rwds_out=0, then addr+1.
    - A register read returns cfg0 for every word.
  - WR:
    - Rise: capture the high byte and its mask. Fall: capture the low byte and its mask.
    - On the fall, commit the unmasked bytes to mem[addr], then addr+1.
    - A register write loads cfg0 with the full word and ignores the mask.
- addr wraps from 2^AW-1 to 0 within a burst.
- hb_cs_l high in any state: on that same clk, go to IDLE and clear all output enables.
  - A write word with only its high byte captured is discarded.
  - If the state was RD or WR and at least one data word completed, txn_count increments.
- Simultaneous hb_cs_l rise and ck edge: the deassertion wins and the edge is ignored.
- Register reads and writes complete in 1 word; any further words keep addressing cfg0.

Test Plan:
- Reset release with CS high -> all outputs 0, busy=0, txn_count=0; a register read afterwards returns 0x8F1F.
- Memory write: CA 0x00_0000_0000_02, LATENCY=6, LAT2X=1, data 0x1234, 0x5678 with rwds low -> mem[2]=0x1234 and mem[3]=0x5678; no dq_oe at any time; txn_count=1.
- Read back from word 2, burst of 2:
  - first data rise comes 12 ck rises after CA;
  - dq sequence 0x12, 0x34, 0x56, 0x78;
  - rwds toggles 1,0,1,0;
  - dq_oe drops one clk after CS rises.
- Masked write to word 2 with data 0xAABB and rwds high on the fall -> mem[2]=0xAA34.
- Wrap: write 2 words starting at word 0x3FF with AW=10 -> words 0x3FF and 0x000 are written.
- Register write 0x8FE6 (CA 0x60_0001_0000_00) with zero latency -> cfg0=0x8FE6. A CS abort after one rise of a memory write leaves the target word unchanged, and busy=0 on the next clk.
